// File: rtl/dma_handshake_monitor_if.sv
// DREQ/DACK/HRQ/HLDA bundle shared by the DMA controller and the passive protocol monitor.
interface dma_handshake_monitor_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] dreq;
  logic [NUM_CH-1:0] dack;
  logic              hrq;
  logic              hlda;

  modport master (output dreq, output dack, output hrq, output hlda);
  modport slave  (input  dreq, input  dack, input  hrq, input  hlda);
endinterface

// File: rtl/dma_handshake_monitor.sv
// Passive DMA handshake monitor: tracks the HRQ/HLDA/DACK sequence, priority order, request
// latency and grant counts, and raises sticky error flags. It never drives the bus.
//   state  | meaning
//   S_IDLE | no hold requested
//   S_REQ  | HRQ raised, waiting for HLDA
//   S_HELD | bus held, no channel acknowledged
//   S_XFER | some DACK active
module dma_handshake_monitor #(
  parameter int NUM_CH  = 4,
  parameter int MAX_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  dma_handshake_monitor_if.slave  bus,
  input  logic                    i_rotate,
  input  logic                    i_clear_err,
  output logic [1:0]              o_mon_state,
  output logic                    o_err_onehot,
  output logic                    o_err_priority,
  output logic                    o_err_timeout,
  output logic [NUM_CH-1:0]       o_err_to_ch,
  output logic                    o_err_proto,
  output logic [NUM_CH*CNT_W-1:0] o_grant_cnt
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HELD = 2'd2,
    S_XFER = 2'd3
  } state_t;

  state_t              r_state;
  logic [NUM_CH-1:0]   r_pdack;
  logic [NUM_CH-1:0]   r_preq;
  logic                r_phrq;
  logic [PTR_W-1:0]    r_last;
  logic [LAT_W-1:0]    r_lat [NUM_CH];
  logic [CNT_W-1:0]    r_cnt [NUM_CH];
  logic                r_err_onehot;
  logic                r_err_priority;
  logic                r_err_timeout;
  logic [NUM_CH-1:0]   r_err_to_ch;
  logic                r_err_proto;

  logic [NUM_CH-1:0]   w_grant;
  logic                w_dack_any;
  logic                w_onehot_err;
  logic                w_proto_err;
  logic                w_prio_err;
  logic [PTR_W-1:0]    w_last_nxt;
  logic [LAT_W-1:0]    w_lat_nxt [NUM_CH];
  logic [NUM_CH-1:0]   w_to_hit;

  // Position of ch in the rotating order that starts just after the last-served channel.
  function automatic int rot_dist(input int ch, input logic [PTR_W-1:0] last);
    int d;
    d = ch - int'(last) - 1;
    if (d < 0) d = d + NUM_CH;
    return d;
  endfunction

  assign w_grant      = bus.dack & ~r_pdack;
  assign w_dack_any   = |bus.dack;
  assign w_onehot_err = ($countones(bus.dack) > 1);
  assign w_proto_err  = (bus.hlda && (r_state == S_IDLE)) ||
                        (w_dack_any && !bus.hlda) ||
                        (r_phrq && !bus.hrq && w_dack_any);

  always_comb begin
    w_prio_err = 1'b0;
    for (int g = 0; g < NUM_CH; g++) begin
      if (w_grant[g]) begin
        for (int j = 0; j < NUM_CH; j++) begin
          if (r_preq[j] && (j != g)) begin
            if (i_rotate) begin
              if (rot_dist(j, r_last) < rot_dist(g, r_last)) w_prio_err = 1'b1;
            end else if (j < g) begin
              w_prio_err = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    w_last_nxt = r_last;
    for (int g = 0; g < NUM_CH; g++) begin
      if (r_pdack[g] && !bus.dack[g]) w_last_nxt = PTR_W'(g);
    end
  end

  // Timeout fires on the edge where the counter lands on MAX_LAT.
  always_comb begin
    w_to_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_lat_nxt[i] = '0;
      if (bus.dreq[i] && !bus.dack[i]) begin
        w_lat_nxt[i] = (r_lat[i] == LAT_MAX) ? LAT_MAX : r_lat[i] + LAT_W'(1);
      end
      w_to_hit[i] = (w_lat_nxt[i] == LAT_MAX);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_pdack        <= '0;
      r_preq         <= '0;
      r_phrq         <= 1'b0;
      r_last         <= PTR_W'(NUM_CH - 1);
      r_err_onehot   <= 1'b0;
      r_err_priority <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_to_ch    <= '0;
      r_err_proto    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_lat[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (bus.hrq) r_state <= S_REQ;
        S_REQ: begin
          if (bus.hlda)      r_state <= S_HELD;
          else if (!bus.hrq) r_state <= S_IDLE;
        end
        S_HELD: begin
          if (w_dack_any)    r_state <= S_XFER;
          else if (!bus.hrq) r_state <= S_IDLE;
        end
        S_XFER: if (!w_dack_any) r_state <= bus.hrq ? S_HELD : S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      r_pdack <= bus.dack;
      r_preq  <= bus.dreq;
      r_phrq  <= bus.hrq;
      r_last  <= w_last_nxt;

      // A fresh error in the clearing cycle still lands.
      r_err_onehot   <= (r_err_onehot   && !i_clear_err) || w_onehot_err;
      r_err_priority <= (r_err_priority && !i_clear_err) || w_prio_err;
      r_err_proto    <= (r_err_proto    && !i_clear_err) || w_proto_err;
      r_err_timeout  <= (r_err_timeout  && !i_clear_err) || (|w_to_hit);
      r_err_to_ch    <= (r_err_to_ch & ~{NUM_CH{i_clear_err}}) | w_to_hit;

      for (int i = 0; i < NUM_CH; i++) begin
        r_lat[i] <= w_lat_nxt[i];
        if (w_grant[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign o_mon_state    = r_state;
  assign o_err_onehot   = r_err_onehot;
  assign o_err_priority = r_err_priority;
  assign o_err_timeout  = r_err_timeout;
  assign o_err_to_ch    = r_err_to_ch;
  assign o_err_proto    = r_err_proto;

  always_comb begin
    o_grant_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) o_grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
  end

endmodule

// File: tb/tb_dma_handshake_monitor.sv
// Scoreboard bench: stimulus queues hand-computed expectations for the cycle after each edge,
// a negedge monitor pops and compares them. A second instance with 2-bit counters covers saturation.
module tb_dma_handshake_monitor;
  localparam int NUM_CH  = 4;
  localparam int MAX_LAT = 8;
  localparam int CNT_W   = 16;
  localparam int CNT_S   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rotate, clear_err;
  dma_handshake_monitor_if #(.NUM_CH(NUM_CH)) bus ();

  logic [1:0]              mon_state, mon_state_s;
  logic                    e_onehot, e_prio, e_timeout, e_proto;
  logic                    s_onehot, s_prio, s_timeout, s_proto;
  logic [NUM_CH-1:0]       e_to_ch, s_to_ch;
  logic [NUM_CH*CNT_W-1:0] gcnt;
  logic [NUM_CH*CNT_S-1:0] gcnt_s;

  dma_handshake_monitor #(.NUM_CH(NUM_CH), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave), .i_rotate(rotate), .i_clear_err(clear_err),
    .o_mon_state(mon_state), .o_err_onehot(e_onehot), .o_err_priority(e_prio),
    .o_err_timeout(e_timeout), .o_err_to_ch(e_to_ch), .o_err_proto(e_proto), .o_grant_cnt(gcnt)
  );

  dma_handshake_monitor #(.NUM_CH(NUM_CH), .MAX_LAT(MAX_LAT), .CNT_W(CNT_S)) dut_s (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus.slave), .i_rotate(rotate), .i_clear_err(clear_err),
    .o_mon_state(mon_state_s), .o_err_onehot(s_onehot), .o_err_priority(s_prio),
    .o_err_timeout(s_timeout), .o_err_to_ch(s_to_ch), .o_err_proto(s_proto), .o_grant_cnt(gcnt_s)
  );

  // kinds: 0 state, 1 onehot, 2 priority, 3 timeout, 4 to_ch, 5 proto,
  //        10+i grant count ch i, 20+i grant count ch i of the 2-bit instance
  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_val(input int k);
    if (k >= 20 && k < 20 + NUM_CH) return int'(gcnt_s[(k-20)*CNT_S +: CNT_S]);
    if (k >= 10 && k < 10 + NUM_CH) return int'(gcnt[(k-10)*CNT_W +: CNT_W]);
    case (k)
      0: return int'(mon_state);
      1: return int'(e_onehot);
      2: return int'(e_prio);
      3: return int'(e_timeout);
      4: return int'(e_to_ch);
      5: return int'(e_proto);
      default: return -1;
    endcase
  endfunction

  task automatic exp_next(input string n, input int k, input int v);
    exp_t e;
    e.cyc = cyc + 1;
    e.kind = k;
    e.val = v;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic hrq, input logic hlda, input logic [3:0] dreq, input logic [3:0] dack);
    bus.hrq  = hrq;
    bus.hlda = hlda;
    bus.dreq = dreq;
    bus.dack = dack;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        int   a;
        e = q.pop_front();
        a = get_val(e.kind);
        checks++;
        if (a != e.val || e.cyc != cyc) begin
          failures++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d, due %0d)", e.name, a, e.val, cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rotate = 1'b0; clear_err = 1'b0;
    drv(0, 0, 4'b0000, 4'b0000);
    step(); step();
    rst_n = 1'b1;

    // T1: enter XFER on ch1, reset mid-transfer, then grant ch0 from the clean state
    drv(1, 0, 4'b0010, 4'b0000); exp_next("t1_req", 0, 1); step();
    drv(1, 1, 4'b0010, 4'b0000); exp_next("t1_held", 0, 2); step();
    drv(1, 1, 4'b0010, 4'b0010); exp_next("t1_xfer", 0, 3); exp_next("t1_g1_pre", 11, 1); step();
    rst_n = 1'b0; exp_next("t1_rst1_state", 0, 0); step();
    drv(0, 0, 4'b0000, 4'b0000);
    exp_next("t1_rst_state", 0, 0); exp_next("t1_rst_g1", 11, 0); exp_next("t1_rst_proto", 5, 0);
    exp_next("t1_rst_onehot", 1, 0); exp_next("t1_rst_prio", 2, 0); exp_next("t1_rst_to", 3, 0);
    exp_next("t1_rst_toch", 4, 0);
    step();
    rst_n = 1'b1;
    drv(1, 0, 4'b0001, 4'b0000); step();
    drv(1, 1, 4'b0001, 4'b0000); step();
    drv(1, 1, 4'b0001, 4'b0001);
    exp_next("t1_g0", 10, 1); exp_next("t1_xfer2", 0, 3); exp_next("t1_proto", 5, 0); step();
    drv(1, 1, 4'b0000, 4'b0000); exp_next("t1_back_held", 0, 2); step();

    // T2: fixed priority
    rotate = 1'b0;
    drv(1, 1, 4'b0011, 4'b0000); step();
    drv(1, 1, 4'b0011, 4'b0001); exp_next("t2_fix_ok", 2, 0); exp_next("t2_g0", 10, 2); step();
    drv(1, 1, 4'b0011, 4'b0000); step();
    drv(1, 1, 4'b0011, 4'b0010); exp_next("t2_fix_err", 2, 1); exp_next("t2_g1", 11, 1); step();
    drv(1, 1, 4'b0011, 4'b0000); step();
    clear_err = 1'b1; exp_next("t2_clear", 2, 0); step();
    clear_err = 1'b0;

    // T3: rotating priority, last=1 at entry
    rotate = 1'b1;
    drv(1, 1, 4'b0011, 4'b0001); exp_next("t3_rot_ok0", 2, 0); step();
    drv(1, 1, 4'b0011, 4'b0000); step();
    drv(1, 1, 4'b0010, 4'b0000); step();
    drv(1, 1, 4'b0010, 4'b0010); exp_next("t3_rot_ok1", 2, 0); exp_next("t3_g1", 11, 2); step();
    drv(1, 1, 4'b0010, 4'b0000); step();
    drv(1, 1, 4'b0011, 4'b0000); step();
    drv(1, 1, 4'b0011, 4'b0010); clear_err = 1'b1;
    exp_next("t3_rot_err_wins_clear", 2, 1); step();
    clear_err = 1'b0;
    drv(0, 0, 4'b0000, 4'b0000);
    exp_next("t3_idle", 0, 0); exp_next("t3_no_to", 3, 0); exp_next("t3_proto", 5, 0); step();

    // T4: timeout on ch2
    for (int k = 1; k <= MAX_LAT; k++) begin
      drv(0, 0, 4'b0100, 4'b0000);
      if (k == MAX_LAT - 1) begin
        exp_next("t4_to_early", 3, 0); exp_next("t4_toch_early", 4, 0);
      end
      if (k == MAX_LAT) begin
        exp_next("t4_to", 3, 1); exp_next("t4_toch", 4, 4);
      end
      step();
    end
    drv(0, 0, 4'b0000, 4'b0000); clear_err = 1'b1;
    exp_next("t4_to_clr", 3, 0); exp_next("t4_toch_clr", 4, 0); step();
    clear_err = 1'b0;

    // T5: protocol and one-hot violations, then clear
    drv(0, 0, 4'b0000, 4'b0001);
    exp_next("t5_proto", 5, 1); exp_next("t5_onehot_no", 1, 0); exp_next("t5_prio_no", 2, 0);
    exp_next("t5_g0", 10, 4); step();
    drv(0, 0, 4'b0000, 4'b0011); exp_next("t5_onehot", 1, 1); exp_next("t5_g1", 11, 4); step();
    drv(0, 0, 4'b0000, 4'b0000); clear_err = 1'b1;
    exp_next("t5_proto_clr", 5, 0); exp_next("t5_onehot_clr", 1, 0); step();
    clear_err = 1'b0;

    // T6: five grants to ch3; 2-bit counter saturates at 3
    rotate = 1'b0;
    drv(1, 0, 4'b0000, 4'b0000); step();
    drv(1, 1, 4'b0000, 4'b0000); step();
    for (int k = 1; k <= 5; k++) begin
      drv(1, 1, 4'b0000, 4'b1000);
      exp_next("t6_sat_cnt", 23, (k < 3) ? k : 3);
      if (k == 5) exp_next("t6_full_cnt", 13, 5);
      step();
      drv(1, 1, 4'b0000, 4'b0000); exp_next("t6_held", 0, 2); step();
    end
    drv(0, 0, 4'b0000, 4'b0000); exp_next("t6_proto", 5, 0); exp_next("t6_idle", 0, 0); step();
    step(); step();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
